// File: rtl/accum_arbiter.sv
// Round-robin scheduler that shares one accumulator among NREQ packet sources.
// Optional build macro ACC_SAT_EN: saturating add plus a res_sat_o result flag.
module accum_arbiter #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4,
  parameter int ID_W  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid_i,
  input  logic [NREQ*WIDTH-1:0] req_data_i,
  input  logic [NREQ-1:0]       req_last_i,
  output logic [NREQ-1:0]       req_ready_o,
  output logic                  res_valid_o,
  output logic [WIDTH-1:0]      res_data_o,
  output logic [ID_W-1:0]       res_id_o,
`ifdef ACC_SAT_EN
  output logic                  res_sat_o,
`endif
  input  logic                  res_ready_i,
  output logic                  busy_o
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] acc_q;
  logic [ID_W-1:0]  ptr_q;
  logic [ID_W-1:0]  grant_q;
  logic [NREQ-1:0]  req_ready_q;
  logic             res_valid_q;
  logic [WIDTH-1:0] res_data_q;
  logic [ID_W-1:0]  res_id_q;

  logic [WIDTH-1:0] word;
  logic             beat;
  logic [WIDTH-1:0] acc_d;
  logic             add_sat;

  logic [NREQ-1:0]  rot;
  logic [ID_W-1:0]  win_off;
  logic [ID_W:0]    win_sum;
  logic [ID_W-1:0]  win_idx;
  logic [ID_W-1:0]  next_ptr;

  assign word = req_data_i[grant_q*WIDTH +: WIDTH];
  assign beat = req_valid_i[grant_q];

`ifdef ACC_SAT_EN
  logic             sat_q;
  logic             res_sat_q;
  logic [WIDTH:0]   sum;

  assign sum     = {1'b0, acc_q} + {1'b0, word};
  assign add_sat = sum[WIDTH];
  assign acc_d   = add_sat ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
  assign res_sat_o = res_sat_q;
`else
  assign add_sat = 1'b0;
  assign acc_d   = acc_q + word;
`endif

  // Rotate the request vector so bit 0 is the requester at ptr; the lowest
  // set bit of the rotated vector is the round-robin winner's offset.
  assign rot = NREQ'({req_valid_i, req_valid_i} >> ptr_q);

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    win_off = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) win_off = ID_W'(k);
    end
  end

  assign win_sum  = {1'b0, ptr_q} + {1'b0, win_off};
  assign win_idx  = (win_sum >= (ID_W+1)'(NREQ)) ? ID_W'(win_sum - (ID_W+1)'(NREQ))
                                                 : win_sum[ID_W-1:0];
  assign next_ptr = (grant_q == ID_W'(NREQ - 1)) ? '0 : grant_q + 1'b1;

  // NOTE: state registers use non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      ptr_q       <= '0;
      grant_q     <= '0;
      req_ready_q <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
`ifdef ACC_SAT_EN
      sat_q       <= 1'b0;
      res_sat_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_valid_i) begin
            grant_q     <= win_idx;
            req_ready_q <= NREQ'(1) << win_idx;
`ifdef ACC_SAT_EN
            sat_q       <= 1'b0;
`endif
            state_q     <= ACC;
          end
        end
        ACC: begin
          // Bubbles (valid low) leave acc and state alone; req_last is ignored.
          if (beat) begin
            acc_q <= acc_d;
`ifdef ACC_SAT_EN
            sat_q <= sat_q | add_sat;
`endif
            if (req_last_i[grant_q]) begin
              req_ready_q <= '0;
              res_valid_q <= 1'b1;
              res_data_q  <= acc_d;
              res_id_q    <= grant_q;
`ifdef ACC_SAT_EN
              res_sat_q   <= sat_q | add_sat;
`endif
              state_q     <= DONE;
            end
          end
        end
        DONE: begin
          if (res_ready_i) begin
            res_valid_q <= 1'b0;
            acc_q       <= '0;
            ptr_q       <= next_ptr;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o = req_ready_q;
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;
  assign res_id_o    = res_id_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_accum_arbiter.sv
// Directed self-checking bench for accum_arbiter (4 requesters, 16-bit data).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_accum_arbiter;

  localparam int WIDTH = 16;
  localparam int NREQ  = 4;
  localparam int ID_W  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              res_valid;
  logic [WIDTH-1:0]  res_data;
  logic [ID_W-1:0]   res_id;
  logic              res_ready;
  logic              busy;
`ifdef ACC_SAT_EN
  logic              res_sat;
`endif

  int errors = 0;
  int checks = 0;

  // Per-requester word streams and captured results.
  logic [WIDTH-1:0] wq[NREQ][$];
  logic             lq[NREQ][$];
  logic [WIDTH-1:0] rd_q[$];
  logic [ID_W-1:0]  rid_q[$];
  logic             rsat_q[$];

  always #5 clk = ~clk;

  accum_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_last_i  (req_last),
    .req_ready_o (req_ready),
    .res_valid_o (res_valid),
    .res_data_o  (res_data),
    .res_id_o    (res_id),
`ifdef ACC_SAT_EN
    .res_sat_o   (res_sat),
`endif
    .res_ready_i (res_ready),
    .busy_o      (busy)
  );

  task automatic set_word(input int i, input logic v, input logic [WIDTH-1:0] d, input logic l);
    req_valid[i] = v;
    req_data[i*WIDTH +: WIDTH] = d;
    req_last[i] = l;
  endtask

  task automatic clear_queues();
    for (int i = 0; i < NREQ; i++) begin
      wq[i].delete();
      lq[i].delete();
    end
    rd_q.delete();
    rid_q.delete();
    rsat_q.delete();
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    res_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clear_queues();
  endtask

  task automatic push(input int i, input logic [WIDTH-1:0] d, input logic l);
    wq[i].push_back(d);
    lq[i].push_back(l);
  endtask

  // Streams the queued words (valid held while a requester has words left)
  // and records results until `want` have been seen or the budget runs out.
  task automatic run(input int want, input int max_cycles, output bit timed_out);
    logic [NREQ-1:0] rdy_prev;
    logic [NREQ-1:0] vld_prev;
    int got;
    rdy_prev  = '0;
    vld_prev  = '0;
    got       = 0;
    timed_out = 1'b1;
    res_ready = 1'b1;
    for (int c = 0; c < max_cycles; c++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (rdy_prev[i] && vld_prev[i]) begin
          wq[i].delete(0);
          lq[i].delete(0);
        end
      end
      if (res_valid) begin
        rd_q.push_back(res_data);
        rid_q.push_back(res_id);
`ifdef ACC_SAT_EN
        rsat_q.push_back(res_sat);
`else
        rsat_q.push_back(1'b0);
`endif
        got++;
      end
      if (got >= want) begin
        timed_out = 1'b0;
        break;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (wq[i].size() > 0) set_word(i, 1'b1, wq[i][0], lq[i][0]);
        else                  set_word(i, 1'b0, '0, 1'b0);
      end
      rdy_prev = req_ready;
      vld_prev = req_valid;
    end
    req_valid = '0;
    req_last  = '0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
    checks++; if (res_data !== 16'h0000) begin errors++; $display("FAIL reset_res_data: got %h want 0000", res_data); end
    checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL reset_res_id: got %0d want 0", res_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
`ifdef ACC_SAT_EN
    checks++; if (res_sat !== 1'b0) begin errors++; $display("FAIL reset_res_sat: got %b want 0", res_sat); end
`endif
  endtask

  // Packet 3,5,7 on requester 0: grant, three beats, one result cycle.
  task automatic test_single();
    res_ready = 1'b1;
    set_word(0, 1'b1, 16'd3, 1'b0);
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b want 0001", req_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
    @(negedge clk);
    set_word(0, 1'b1, 16'd5, 1'b0);
    @(negedge clk);
    set_word(0, 1'b1, 16'd7, 1'b1);
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b want 0", res_valid); end
    @(negedge clk);
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL single_res_valid: got %b want 1", res_valid); end
    checks++; if (res_data !== 16'd15) begin errors++; $display("FAIL single_res_data: got %0d want 15", res_data); end
    checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL single_res_id: got %0d want 0", res_id); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_ready_done: got %b want 0000", req_ready); end
    set_word(0, 1'b0, '0, 1'b0);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_total_cycles: busy got %b want 0", busy); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_res_clear: got %b want 0", res_valid); end
  endtask

  task automatic test_round_robin();
    bit to;
    logic [ID_W-1:0]  exp_id[4];
    logic [WIDTH-1:0] exp_d[4];
    do_reset();
    for (int i = 0; i < NREQ; i++) push(i, WIDTH'(i + 1), 1'b1);
    run(4, 80, to);
    checks++; if (to) begin errors++; $display("FAIL rr_all_timeout: got %0d results want 4", rd_q.size()); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= rd_q.size() || rid_q[k] !== ID_W'(k) || rd_q[k] !== WIDTH'(k + 1)) begin
        errors++;
        $display("FAIL rr_all_%0d: got id %0d data %0d want id %0d data %0d", k, rid_q[k], rd_q[k], k, k + 1);
      end
    end
    rd_q.delete(); rid_q.delete(); rsat_q.delete();
    for (int k = 0; k < 4; k++) begin
      push(0, WIDTH'(16'h10 + k), 1'b1);
      push(2, WIDTH'(16'h20 + k), 1'b1);
    end
    exp_id = '{2'd0, 2'd2, 2'd0, 2'd2};
    exp_d  = '{16'h10, 16'h20, 16'h11, 16'h21};
    run(4, 80, to);
    checks++; if (to) begin errors++; $display("FAIL rr_hold_timeout: got %0d results want 4", rd_q.size()); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= rd_q.size() || rid_q[k] !== exp_id[k] || rd_q[k] !== exp_d[k]) begin
        errors++;
        $display("FAIL rr_hold_%0d: got id %0d data %h want id %0d data %h", k, rid_q[k], rd_q[k], exp_id[k], exp_d[k]);
      end
    end
    clear_queues();
  endtask

  // Result held for several cycles while others request; ptr moves only on handshake.
  task automatic test_stall();
    do_reset();
    res_ready = 1'b0;
    set_word(1, 1'b1, 16'h0042, 1'b1);
    set_word(3, 1'b1, 16'h0099, 1'b1);
    @(negedge clk);
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL stall_grant: got %b want 0010", req_ready); end
    @(negedge clk);
    set_word(1, 1'b0, '0, 1'b0);
    set_word(0, 1'b1, 16'h0055, 1'b1);
    for (int s = 0; s < 6; s++) begin
      if (s > 0) @(negedge clk);
      if (res_valid !== 1'b1 || res_data !== 16'h0042 || res_id !== 2'd1 || req_ready !== 4'b0000 || busy !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold_%0d: got valid %b data %h id %0d ready %b busy %b want 1 0042 1 0000 1",
                 s, res_valid, res_data, res_id, req_ready, busy);
      end
      checks++;
    end
    res_ready = 1'b1;
    @(negedge clk);
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL stall_release: got %b want 0", res_valid); end
    @(negedge clk);
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL stall_next_grant: got %b want 1000", req_ready); end
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b1 || res_data !== 16'h0099 || res_id !== 2'd3) begin
      errors++;
      $display("FAIL stall_held_word: got valid %b data %h id %0d want 1 0099 3", res_valid, res_data, res_id);
    end
    set_word(3, 1'b0, '0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL stall_wrap_grant: got %b want 0001", req_ready); end
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b1 || res_data !== 16'h0055 || res_id !== 2'd0) begin
      errors++;
      $display("FAIL stall_req0_result: got valid %b data %h id %0d want 1 0055 0", res_valid, res_data, res_id);
    end
    set_word(0, 1'b0, '0, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_wrap();
    bit to;
    logic [WIDTH-1:0] exp_d;
    logic             exp_sat;
`ifdef ACC_SAT_EN
    exp_d = 16'hFFFF; exp_sat = 1'b1;
`else
    exp_d = 16'h0010; exp_sat = 1'b0;
`endif
    do_reset();
    push(2, 16'hFFF0, 1'b0);
    push(2, 16'h0020, 1'b1);
    run(1, 40, to);
    checks++;
    if (to || rd_q[0] !== exp_d || rid_q[0] !== 2'd2 || rsat_q[0] !== exp_sat) begin
      errors++;
      $display("FAIL wrap_sum: got data %h id %0d sat %b want data %h id 2 sat %b", rd_q[0], rid_q[0], rsat_q[0], exp_d, exp_sat);
    end
    rd_q.delete(); rid_q.delete(); rsat_q.delete();
    push(2, 16'd1, 1'b0);
    push(2, 16'd2, 1'b1);
    run(1, 40, to);
    checks++;
    if (to || rd_q[0] !== 16'd3 || rsat_q[0] !== 1'b0) begin
      errors++;
      $display("FAIL wrap_followup: got data %h sat %b want data 0003 sat 0", rd_q[0], rsat_q[0]);
    end
    clear_queues();
  endtask

  task automatic test_bubbles();
    do_reset();
    set_word(1, 1'b1, 16'd10, 1'b0);
    @(negedge clk);
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bubble_grant: got %b want 0010", req_ready); end
    @(negedge clk);
    set_word(1, 1'b0, 16'd999, 1'b1);
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b0 || req_ready !== 4'b0010 || busy !== 1'b1) begin
        errors++;
        $display("FAIL bubble_hold_%0d: got valid %b ready %b busy %b want 0 0010 1", b, res_valid, req_ready, busy);
      end
    end
    set_word(1, 1'b1, 16'd20, 1'b1);
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b1 || res_data !== 16'd30 || res_id !== 2'd1) begin
      errors++;
      $display("FAIL bubble_result: got valid %b data %0d id %0d want 1 30 1", res_valid, res_data, res_id);
    end
    set_word(1, 1'b0, '0, 1'b0);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bubble_idle: got busy %b want 0", busy); end
  endtask

  // Reset mid-packet aborts it and returns ptr to 0 (it was 2 beforehand).
  task automatic test_reset_mid();
    bit to;
    do_reset();
    push(1, 16'd5, 1'b1);
    run(1, 40, to);
    checks++; if (to || rd_q[0] !== 16'd5) begin errors++; $display("FAIL midrst_setup: got data %0d want 5", rd_q[0]); end
    @(negedge clk);
    set_word(2, 1'b1, 16'd1, 1'b0);
    @(negedge clk);
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL midrst_grant: got %b want 0100", req_ready); end
    @(negedge clk);
    set_word(2, 1'b1, 16'd2, 1'b0);
    @(negedge clk);
    set_word(2, 1'b1, 16'd3, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_abort: got busy %b valid %b ready %b want 0 0 0000", busy, res_valid, req_ready);
    end
    reset = 1'b0;
    set_word(2, 1'b0, '0, 1'b0);
    clear_queues();
    push(0, 16'd1, 1'b0);
    push(0, 16'd1, 1'b1);
    push(3, 16'd7, 1'b1);
    run(2, 60, to);
    checks++; if (to) begin errors++; $display("FAIL midrst_timeout: got %0d results want 2", rd_q.size()); end
    checks++;
    if (rid_q[0] !== 2'd0 || rd_q[0] !== 16'd2) begin
      errors++;
      $display("FAIL midrst_fresh: got id %0d data %0d want id 0 data 2", rid_q[0], rd_q[0]);
    end
    checks++;
    if (rid_q[1] !== 2'd3 || rd_q[1] !== 16'd7) begin
      errors++;
      $display("FAIL midrst_second: got id %0d data %0d want id 3 data 7", rid_q[1], rd_q[1]);
    end
    clear_queues();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_wrap();
    test_bubbles();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
